// File: rtl/dpll_loop_ctrl.sv
// Phase detector and PI loop filter for the DPLL. Measures the clk-cycle distance between
// reference and feedback rising edges, filters it, and drives the divider's N value.
module dpll_loop_ctrl #(
  parameter logic [7:0]  N_INIT   = 8'd49,
  parameter logic [7:0]  N_MIN    = 8'd1,
  parameter logic [7:0]  N_MAX    = 8'd254,
  parameter int unsigned KP_SHIFT = 2,
  parameter int unsigned KI_SHIFT = 5,
  parameter int unsigned ERR_W    = 12,
  parameter int unsigned LOCK_TOL = 2,
  parameter int unsigned LOCK_CNT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ref_in,
  input  logic                    fb_in,
  output logic [7:0]              N,
  output logic                    n_valid,
  output logic signed [ERR_W-1:0] phase_err,
  output logic                    lock
);

  localparam int unsigned CW  = ERR_W - 1;
  localparam int unsigned LCW = $clog2(LOCK_CNT + 1);
  localparam int unsigned WW  = ERR_W + 2;

  localparam logic [CW-1:0]           CntMax  = '1;
  localparam logic signed [ERR_W-1:0] ErrMax  = {1'b0, CntMax};
  localparam logic signed [WW-1:0]    ErrMaxW = {3'b000, CntMax};
  localparam logic signed [WW-1:0]    NInitW  = {{(WW-8){1'b0}}, N_INIT};
  localparam logic signed [WW-1:0]    NMinW   = {{(WW-8){1'b0}}, N_MIN};
  localparam logic signed [WW-1:0]    NMaxW   = {{(WW-8){1'b0}}, N_MAX};
  localparam logic [LCW-1:0]          LockMax = LCW'(LOCK_CNT);

  typedef enum logic [1:0] {StIdle, StWaitFb, StWaitRef, StUpdate} state_e;

  state_e                  state_q, state_d;
  logic [2:0]              ref_sync_q, ref_sync_d, fb_sync_q, fb_sync_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic signed [ERR_W-1:0] err_q, err_d, integ_q, integ_d;
  logic [7:0]              n_q, n_d;
  logic                    n_valid_q, n_valid_d, lock_q, lock_d;
  logic                    pend_ref_q, pend_ref_d, pend_fb_q, pend_fb_d;
  logic [LCW-1:0]          lock_cnt_q, lock_cnt_d;

  logic                    ref_edge, fb_edge, open_ref, open_fb;
  logic [CW-1:0]           cnt_nxt;
  logic signed [ERR_W-1:0] kp_term, ki_term;
  logic signed [WW-1:0]    kp_w, ki_w, integ_w, isum_w, isat_w, n_w;
  logic [ERR_W-1:0]        abs_err;
  logic                    in_tol;

  // Identical 3-FF chains so ref and fb pin-to-pulse latencies match.
  always_comb begin
    ref_sync_d = {ref_sync_q[1:0], ref_in};
    fb_sync_d  = {fb_sync_q[1:0], fb_in};
    ref_edge   = ref_sync_q[1] & ~ref_sync_q[2];
    fb_edge    = fb_sync_q[1] & ~fb_sync_q[2];
  end

  // Loop filter arithmetic, evaluated every cycle but only committed in StUpdate.
  always_comb begin
    kp_term = err_q >>> KP_SHIFT;
    ki_term = err_q >>> KI_SHIFT;
    kp_w    = {{2{kp_term[ERR_W-1]}}, kp_term};
    ki_w    = {{2{ki_term[ERR_W-1]}}, ki_term};
    integ_w = {{2{integ_q[ERR_W-1]}}, integ_q};
    isum_w  = integ_w + ki_w;
    if (isum_w > ErrMaxW) begin
      isat_w = ErrMaxW;
    end else if (isum_w < -ErrMaxW) begin
      isat_w = -ErrMaxW;
    end else begin
      isat_w = isum_w;
    end
    n_w     = NInitW - (kp_w + isat_w);
    abs_err = err_q[ERR_W-1] ? ERR_W'(-err_q) : ERR_W'(err_q);
    in_tol  = abs_err <= ERR_W'(LOCK_TOL);
    cnt_nxt = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
  end

  // Measurement FSM and update of N / integrator / lock.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    integ_d    = integ_q;
    n_d        = n_q;
    n_valid_d  = 1'b0;
    lock_d     = lock_q;
    lock_cnt_d = lock_cnt_q;
    pend_ref_d = pend_ref_q;
    pend_fb_d  = pend_fb_q;
    open_ref   = ref_edge | pend_ref_q;
    open_fb    = fb_edge | pend_fb_q;
    unique case (state_q)
      StIdle: begin
        pend_ref_d = 1'b0;
        pend_fb_d  = 1'b0;
        if (open_ref && open_fb) begin
          err_d   = '0;
          state_d = StUpdate;
        end else if (open_ref) begin
          cnt_d   = '0;
          state_d = StWaitFb;
        end else if (open_fb) begin
          cnt_d   = '0;
          state_d = StWaitRef;
        end
      end
      StWaitFb: begin
        cnt_d = cnt_nxt;
        if (fb_edge) begin
          err_d   = {1'b0, cnt_nxt};
          state_d = StUpdate;
        end else if (ref_edge || cnt_nxt == CntMax) begin
          err_d   = ErrMax;
          state_d = StUpdate;
        end
      end
      StWaitRef: begin
        cnt_d = cnt_nxt;
        if (ref_edge) begin
          err_d   = -$signed({1'b0, cnt_nxt});
          state_d = StUpdate;
        end else if (fb_edge || cnt_nxt == CntMax) begin
          err_d   = -ErrMax;
          state_d = StUpdate;
        end
      end
      StUpdate: begin
        // Edges landing here would otherwise be lost; replay them in StIdle.
        pend_ref_d = ref_edge;
        pend_fb_d  = fb_edge;
        integ_d    = isat_w[ERR_W-1:0];
        if (n_w < NMinW) begin
          n_d = N_MIN;
        end else if (n_w > NMaxW) begin
          n_d = N_MAX;
        end else begin
          n_d = n_w[7:0];
        end
        n_valid_d = 1'b1;
        if (in_tol) begin
          lock_cnt_d = (lock_cnt_q == LockMax) ? lock_cnt_q : lock_cnt_q + 1'b1;
          lock_d     = (lock_cnt_d == LockMax);
        end else begin
          lock_cnt_d = '0;
          lock_d     = 1'b0;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      ref_sync_q <= '0;
      fb_sync_q  <= '0;
      cnt_q      <= '0;
      err_q      <= '0;
      integ_q    <= '0;
      n_q        <= N_INIT;
      n_valid_q  <= 1'b0;
      lock_q     <= 1'b0;
      lock_cnt_q <= '0;
      pend_ref_q <= 1'b0;
      pend_fb_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ref_sync_q <= ref_sync_d;
      fb_sync_q  <= fb_sync_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      integ_q    <= integ_d;
      n_q        <= n_d;
      n_valid_q  <= n_valid_d;
      lock_q     <= lock_d;
      lock_cnt_q <= lock_cnt_d;
      pend_ref_q <= pend_ref_d;
      pend_fb_q  <= pend_fb_d;
    end
  end

  assign N         = n_q;
  assign n_valid   = n_valid_q;
  assign phase_err = err_q;
  assign lock      = lock_q;

endmodule

// File: tb/tb_dpll_loop_ctrl.sv
// Directed bench for dpll_loop_ctrl: edge spacings with hand-computed errors and N values.
module tb_dpll_loop_ctrl;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              ref_in = 1'b0;
  logic              fb_in = 1'b0;
  logic [7:0]        N;
  logic              n_valid;
  logic signed [11:0] phase_err;
  logic              lock;

  int total = 0;
  int bad = 0;
  int nv_cnt = 0;

  dpll_loop_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .ref_in    (ref_in),
    .fb_in     (fb_in),
    .N         (N),
    .n_valid   (n_valid),
    .phase_err (phase_err),
    .lock      (lock)
  );

  always #5 clk = ~clk;

  // Advance n cycles, sampling 1 time unit after each rising edge and counting n_valid pulses.
  task automatic run(input int n);
    nv_cnt = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (n_valid) nv_cnt++;
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    ref_in = 1'b0;
    fb_in  = 1'b0;
    run(3);
    reset = 1'b0;
  endtask

  initial begin
    // T1: reset values, then idle with no edges.
    do_reset();
    check("t1_n", int'(N), 49);
    check("t1_nvalid", int'(n_valid), 0);
    check("t1_lock", int'(lock), 0);
    check("t1_perr", int'(phase_err), 0);
    run(10);
    check("t1_idle_pulses", nv_cnt, 0);

    // T2: aligned edges.
    ref_in = 1'b1;
    fb_in  = 1'b1;
    run(10);
    check("t2_pulses", nv_cnt, 1);
    check("t2_perr", int'(phase_err), 0);
    check("t2_n", int'(N), 49);

    // T3: fb lags ref by 8 cycles -> err +8, N = 49 - 2.
    do_reset();
    run(2);
    ref_in = 1'b1;
    run(8);
    fb_in = 1'b1;
    run(10);
    check("t3_perr", int'(phase_err), 8);
    check("t3_n", int'(N), 47);
    check("t3_pulses", nv_cnt, 1);

    // T4: fb leads by 40 -> err -40, kp -10, integ -2, N = 61.
    do_reset();
    run(2);
    fb_in = 1'b1;
    run(40);
    ref_in = 1'b1;
    run(10);
    check("t4_perr", int'(phase_err), -40);
    check("t4_n", int'(N), 61);
    check("t4_pulses", nv_cnt, 1);

    // T5a: two ref edges with no fb -> slip +2047, N clamps low.
    do_reset();
    run(2);
    ref_in = 1'b1;
    run(5);
    ref_in = 1'b0;
    run(5);
    ref_in = 1'b1;
    run(10);
    check("t5_ref_perr", int'(phase_err), 2047);
    check("t5_ref_n", int'(N), 1);
    check("t5_ref_pulses", nv_cnt, 1);

    // T5b: two fb edges with no ref -> slip -2047, N clamps high.
    do_reset();
    run(2);
    fb_in = 1'b1;
    run(5);
    fb_in = 1'b0;
    run(5);
    fb_in = 1'b1;
    run(10);
    check("t5_fb_perr", int'(phase_err), -2047);
    check("t5_fb_n", int'(N), 254);
    check("t5_fb_pulses", nv_cnt, 1);

    // T6: lock after 16 aligned updates, lost on err +5.
    do_reset();
    run(2);
    for (int i = 1; i <= 16; i++) begin
      ref_in = 1'b1;
      fb_in  = 1'b1;
      run(6);
      if (i == 1) check("t6_first_pulse", nv_cnt, 1);
      ref_in = 1'b0;
      fb_in  = 1'b0;
      run(3);
      if (i == 15) check("t6_lock_15", int'(lock), 0);
      if (i == 16) check("t6_lock_16", int'(lock), 1);
    end
    check("t6_n_locked", int'(N), 49);
    ref_in = 1'b1;
    run(5);
    fb_in = 1'b1;
    run(10);
    check("t6_err5_perr", int'(phase_err), 5);
    check("t6_err5_lock", int'(lock), 0);
    check("t6_err5_n", int'(N), 48);

    // T6: reset while waiting for fb aborts the measurement.
    do_reset();
    run(2);
    ref_in = 1'b1;
    run(4);
    reset = 1'b1;
    run(2);
    reset  = 1'b0;
    ref_in = 1'b0;
    run(20);
    check("t6_abort_pulses", nv_cnt, 0);
    check("t6_abort_n", int'(N), 49);
    check("t6_abort_perr", int'(phase_err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
